decade_ring_chain: RTL and testbench

Parametrised multi-digit counter built from cascaded "2 of 5" decade rings, for buffer address and byte-count stepping in the control unit. Each digit steps through the 2-of-5 buffer-ring sequence. The chain adds several things a single ring does not have:
- configurable digit count and clear value;
- reverse stepping;
- parallel load;
- ripple carry/borrow between digits, plus chain carry-out/borrow-out pulses;
- zero detect and code-validity checking.

---
 rtl/decade_ring_chain.sv | 153 +++++++++++++++
 tb/tb_decade_ring_chain.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/decade_ring_chain.sv
// decade_ring_chain: cascaded 2-of-5 decade rings with up/down stepping,
// parallel load, single-edge all-nines/all-zeros ripple, chain wrap pulses,
// zero detect and code-validity flag.
module decade_ring_chain #(
  parameter int DIGITS    = 3,
  parameter int CLR_DIGIT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic                  i_retard,
  input  logic                  i_load,
  input  logic [5*DIGITS-1:0]   i_load_value,
  output logic [5*DIGITS-1:0]   o_output,
  output logic                  o_zero,
  output logic                  o_carry,
  output logic                  o_borrow,
  output logic                  o_check
);

  localparam logic [4:0] CODE_ZERO = 5'b00011;
  localparam logic [4:0] CODE_NINE = 5'b00101;

  // Decimal value to {a,b,c,d,e} ring code.
  function automatic logic [4:0] enc_digit(input logic [3:0] v);
    logic [4:0] c;
    case (v)
      4'd0:    c = 5'b00011;
      4'd1:    c = 5'b10010;
      4'd2:    c = 5'b10001;
      4'd3:    c = 5'b01001;
      4'd4:    c = 5'b11000;
      4'd5:    c = 5'b10100;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b01010;
      4'd8:    c = 5'b00110;
      4'd9:    c = 5'b00101;
      default: c = 5'b00011;
    endcase
    return c;
  endfunction

  // Ring code to decimal value; only meaningful for valid codes.
  function automatic logic [3:0] dec_digit(input logic [4:0] c);
    logic [3:0] v;
    case (c)
      5'b00011: v = 4'd0;
      5'b10010: v = 4'd1;
      5'b10001: v = 4'd2;
      5'b01001: v = 4'd3;
      5'b11000: v = 4'd4;
      5'b10100: v = 4'd5;
      5'b01100: v = 4'd6;
      5'b01010: v = 4'd7;
      5'b00110: v = 4'd8;
      5'b00101: v = 4'd9;
      default:  v = 4'd0;
    endcase
    return v;
  endfunction

  // Every code with exactly two ones is one of the ten decimal codes.
  function automatic logic code_ok(input logic [4:0] c);
    logic [2:0] n;
    n = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]} + {2'b00, c[4]};
    return (n == 3'd2);
  endfunction

  function automatic logic [4:0] succ_code(input logic [4:0] c);
    logic [3:0] v;
    v = dec_digit(c);
    return (v == 4'd9) ? enc_digit(4'd0) : enc_digit(v + 4'd1);
  endfunction

  function automatic logic [4:0] pred_code(input logic [4:0] c);
    logic [3:0] v;
    v = dec_digit(c);
    return (v == 4'd0) ? enc_digit(4'd9) : enc_digit(v - 4'd1);
  endfunction

  localparam logic [4:0] CLR_CODE = enc_digit(4'(CLR_DIGIT));

  logic [5*DIGITS-1:0] out_q, out_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;

  // Next state: clear over load over stepping; ripple enables resolve in one edge.
  always_comb begin
    logic            step_up;
    logic            step_dn;
    logic [DIGITS:0] en_up;
    logic [DIGITS:0] en_dn;
    logic [4:0]      cur;
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    step_up  = i_advance & ~i_retard;
    step_dn  = i_retard & ~i_advance;
    en_up    = '0;
    en_dn    = '0;
    en_up[0] = 1'b1;
    en_dn[0] = 1'b1;
    // An invalid digit is neither nine nor zero, so it breaks the ripple.
    for (int k = 0; k < DIGITS; k++) begin
      cur        = out_q[5*k +: 5];
      en_up[k+1] = en_up[k] & (cur == CODE_NINE);
      en_dn[k+1] = en_dn[k] & (cur == CODE_ZERO);
    end
    if (i_clear) begin
      for (int k = 0; k < DIGITS; k++) out_d[5*k +: 5] = CLR_CODE;
    end else if (i_load) begin
      out_d = i_load_value;
    end else if (step_up || step_dn) begin
      for (int k = 0; k < DIGITS; k++) begin
        cur = out_q[5*k +: 5];
        if (code_ok(cur)) begin
          if (step_up && en_up[k]) out_d[5*k +: 5] = succ_code(cur);
          if (step_dn && en_dn[k]) out_d[5*k +: 5] = pred_code(cur);
        end
      end
      carry_d  = step_up & en_up[DIGITS];
      borrow_d = step_dn & en_dn[DIGITS];
    end
  end

  // State register; clear returns the chain to the clear digit value.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int k = 0; k < DIGITS; k++) out_q[5*k +: 5] <= CLR_CODE;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Zero and validity flags decoded straight from the state register.
  always_comb begin
    o_zero  = 1'b1;
    o_check = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (out_q[5*k +: 5] != CODE_ZERO) o_zero = 1'b0;
      if (!code_ok(out_q[5*k +: 5]))    o_check = 1'b1;
    end
  end

  assign o_output = out_q;
  assign o_carry  = carry_q;
  assign o_borrow = borrow_q;

endmodule

// File: tb/tb_decade_ring_chain.sv
// Bench for decade_ring_chain: directed steps plus random traffic against a
// decimal-arithmetic reference model of the chain.
module tb_decade_ring_chain;
  localparam int D   = 3;
  localparam int CLR = 1;
  localparam int W   = 5 * D;

  logic         clk = 1'b0;
  logic         clear, advance, retard, load;
  logic [W-1:0] load_value;
  logic [W-1:0] out;
  logic         zero, carry, borrow, check;

  int checks = 0;
  int errors = 0;

  // Index = decimal value.
  logic [4:0] CODE [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                            5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  logic [4:0] m_code [D];
  logic       m_carry, m_borrow;

  decade_ring_chain #(.DIGITS(D), .CLR_DIGIT(CLR)) dut (
    .i_clk(clk), .i_clear(clear), .i_advance(advance), .i_retard(retard),
    .i_load(load), .i_load_value(load_value), .o_output(out), .o_zero(zero),
    .o_carry(carry), .o_borrow(borrow), .o_check(check)
  );

  always #5 clk = ~clk;

  function automatic int val_of(input logic [4:0] c);
    for (int v = 0; v < 10; v++) if (CODE[v] == c) return v;
    return -1;
  endfunction

  function automatic logic [W-1:0] pack3(input int d2, input int d1, input int d0);
    return {CODE[d2], CODE[d1], CODE[d0]};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model: digits below the first invalid digit form a mod-10^j counter.
  task automatic model_edge(input logic c, input logic l, input logic a, input logic r,
                            input logic [W-1:0] lv);
    int j, n, md, n2;
    m_carry = 1'b0;
    m_borrow = 1'b0;
    if (c) begin
      for (int k = 0; k < D; k++) m_code[k] = CODE[CLR];
    end else if (l) begin
      for (int k = 0; k < D; k++) m_code[k] = lv[5*k +: 5];
    end else if (a != r) begin
      j = D;
      for (int k = D - 1; k >= 0; k--) if (val_of(m_code[k]) < 0) j = k;
      n = 0; md = 1;
      for (int k = 0; k < j; k++) begin
        n += val_of(m_code[k]) * md;
        md *= 10;
      end
      n2 = a ? (n + 1) % md : (n + md - 1) % md;
      for (int k = 0; k < j; k++) begin
        m_code[k] = CODE[n2 % 10];
        n2 /= 10;
      end
      m_carry  = a && (j == D) && (n == md - 1);
      m_borrow = r && (j == D) && (n == 0);
    end
  endtask

  task automatic cyc(input string tag, input logic c, input logic l, input logic a,
                     input logic r, input logic [W-1:0] lv);
    logic [W-1:0] exp_out;
    logic exp_zero, exp_check;
    clear = c; load = l; advance = a; retard = r; load_value = lv;
    model_edge(c, l, a, r, lv);
    @(posedge clk);
    #1;
    exp_zero = 1'b1;
    exp_check = 1'b0;
    for (int k = 0; k < D; k++) begin
      exp_out[5*k +: 5] = m_code[k];
      if (m_code[k] != 5'b00011) exp_zero = 1'b0;
      if ($countones(m_code[k]) != 2) exp_check = 1'b1;
    end
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".zero"}, W'(zero), W'(exp_zero));
    chk({tag, ".carry"}, W'(carry), W'(m_carry));
    chk({tag, ".borrow"}, W'(borrow), W'(m_borrow));
    chk({tag, ".check"}, W'(check), W'(exp_check));
  endtask

  initial begin
    logic [W-1:0] lv;
    clear = 1'b0; load = 1'b0; advance = 1'b0; retard = 1'b0; load_value = '0;
    @(negedge clk);

    cyc("clear", 1, 0, 0, 0, '0);
    chk("clear.lit", out, {3{5'b10010}});

    for (int i = 0; i < 10; i++) cyc("adv10", 0, 0, 1, 0, '0);
    chk("adv10.lit", out, pack3(1, 2, 1));

    cyc("ld999", 0, 1, 0, 0, {3{5'b00101}});
    cyc("wrap_up", 0, 0, 1, 0, '0);
    chk("wrap_up.lit", out, {3{5'b00011}});
    chk("wrap_up.carry_lit", W'(carry), W'(1'b1));
    cyc("after_wrap", 0, 0, 0, 0, '0);

    cyc("ld000", 0, 1, 0, 0, {3{5'b00011}});
    cyc("wrap_dn", 0, 0, 0, 1, '0);
    chk("wrap_dn.lit", out, {3{5'b00101}});
    chk("wrap_dn.borrow_lit", W'(borrow), W'(1'b1));
    cyc("hold_both", 0, 0, 1, 1, '0);
    chk("hold_both.lit", out, {3{5'b00101}});

    cyc("ld_bad", 0, 1, 0, 0, {5'b00101, 5'b00101, 5'b00111});
    cyc("adv_bad", 0, 0, 1, 0, '0);
    chk("adv_bad.lit", out, {5'b00101, 5'b00101, 5'b00111});
    cyc("ld_zero", 0, 1, 0, 0, {3{5'b00011}});

    cyc("ld_999b", 0, 1, 0, 0, {3{5'b00101}});
    cyc("prio_clr", 1, 1, 1, 0, pack3(4, 5, 6));
    chk("prio_clr.lit", out, {3{5'b10010}});
    cyc("prio_ld", 0, 1, 1, 0, pack3(4, 5, 6));
    chk("prio_ld.lit", out, pack3(4, 5, 6));
    cyc("ld_999c", 0, 1, 0, 0, {3{5'b00101}});
    cyc("wrap_clr", 1, 0, 1, 0, '0);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < D; k++) begin
        if ($urandom_range(0, 7) == 0) lv[5*k +: 5] = 5'($urandom);
        else if ($urandom_range(0, 1) == 0) lv[5*k +: 5] = CODE[$urandom_range(0, 1) * 9];
        else lv[5*k +: 5] = CODE[$urandom_range(0, 9)];
      end
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
          1'($urandom), 1'($urandom), lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
